// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory fetch port: request/address out from the fetch stage,
// ready/read data back from the memory.
interface pc_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_stage.sv
// PC register and IF stage: imem handshake, stall hold buffer, flush/redirect and IF/ID register.
// Optional feature macro FETCH_ALIGN_CHECK_EN: force word-aligned PC loads and flag misalignment.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               next_addr,
  input  logic                      stall_if,
  input  logic                      flush_if,
  pc_fetch_stage_if.master          imem,
  output logic [31:0]               pc,
  output logic [31:0]               pc_plus4,
  output logic [31:0]               if_id_ins,
  output logic [31:0]               if_id_pc_plus4,
  output logic                      if_id_valid,
  output logic                      align_err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] redir_pc_reg, redir_pc_next;
  logic [31:0] hold_ins_reg, hold_ins_next;
  logic [31:0] hold_pc_plus4_reg, hold_pc_plus4_next;
  logic [31:0] if_id_ins_reg, if_id_ins_next;
  logic [31:0] if_id_pc_plus4_reg, if_id_pc_plus4_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic        pc_load;
  logic [31:0] load_addr;
  logic [31:0] pc_load_addr;

  assign pc_plus4       = pc_reg + 32'd4;
  assign pc             = pc_reg;
  assign imem.imem_addr = pc_reg;
  assign imem.imem_req  = rst_n && (state_reg != HOLD);
  assign if_id_ins      = if_id_ins_reg;
  assign if_id_pc_plus4 = if_id_pc_plus4_reg;
  assign if_id_valid    = if_id_valid_reg;

`ifdef FETCH_ALIGN_CHECK_EN
  logic align_err_reg, align_err_next;
  assign pc_load_addr = {load_addr[31:2], 2'b00};
  assign align_err    = align_err_reg;

  always_comb begin
    align_err_next = align_err_reg;
    if (pc_load && (load_addr[1:0] != 2'b00))
      align_err_next = 1'b1;
  end
`else
  assign pc_load_addr = load_addr;
  assign align_err    = 1'b0;
`endif

  always_comb begin
    state_next          = state_reg;
    redir_pc_next       = redir_pc_reg;
    hold_ins_next       = hold_ins_reg;
    hold_pc_plus4_next  = hold_pc_plus4_reg;
    if_id_ins_next      = if_id_ins_reg;
    if_id_pc_plus4_next = if_id_pc_plus4_reg;
    if_id_valid_next    = if_id_valid_reg;
    pc_load             = 1'b0;
    load_addr           = next_addr;

    case (state_reg)
      FETCH: begin
        if (imem.imem_ready) begin
          if (flush_if) begin
            pc_load          = 1'b1;
            if_id_valid_next = 1'b0;
          end else if (stall_if) begin
            hold_ins_next      = imem.imem_rdata;
            hold_pc_plus4_next = pc_plus4;
            state_next         = HOLD;
          end else begin
            if_id_ins_next      = imem.imem_rdata;
            if_id_pc_plus4_next = pc_plus4;
            if_id_valid_next    = 1'b1;
            pc_load             = 1'b1;
          end
        end else begin
          // The outstanding request cannot be cancelled, so a flush waits it out in DRAIN.
          if (flush_if) begin
            redir_pc_next    = next_addr;
            if_id_valid_next = 1'b0;
            state_next       = DRAIN;
          end else if (!stall_if) begin
            if_id_valid_next = 1'b0;
          end
        end
      end
      HOLD: begin
        if (flush_if) begin
          pc_load          = 1'b1;
          if_id_valid_next = 1'b0;
          state_next       = FETCH;
        end else if (!stall_if) begin
          if_id_ins_next      = hold_ins_reg;
          if_id_pc_plus4_next = hold_pc_plus4_reg;
          if_id_valid_next    = 1'b1;
          pc_load             = 1'b1;
          state_next          = FETCH;
        end
      end
      DRAIN: begin
        if_id_valid_next = 1'b0;
        if (flush_if)
          redir_pc_next = next_addr;
        if (imem.imem_ready) begin
          pc_load    = 1'b1;
          load_addr  = flush_if ? next_addr : redir_pc_reg;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    pc_next = pc_load ? pc_load_addr : pc_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg          <= FETCH;
      pc_reg             <= RESET_PC;
      redir_pc_reg       <= 32'd0;
      hold_ins_reg       <= 32'd0;
      hold_pc_plus4_reg  <= 32'd0;
      if_id_ins_reg      <= 32'd0;
      if_id_pc_plus4_reg <= 32'd0;
      if_id_valid_reg    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_reg      <= 1'b0;
`endif
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      redir_pc_reg       <= redir_pc_next;
      hold_ins_reg       <= hold_ins_next;
      hold_pc_plus4_reg  <= hold_pc_plus4_next;
      if_id_ins_reg      <= if_id_ins_next;
      if_id_pc_plus4_reg <= if_id_pc_plus4_next;
      if_id_valid_reg    <= if_id_valid_next;
`ifdef FETCH_ALIGN_CHECK_EN
      align_err_reg      <= align_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: sequential fetch, stall, flush, drain, wrap, alignment, mid-flight reset.
module tb_pc_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, flush_if;
  logic        seq_mode;
  logic [31:0] next_addr_drv;
  logic [31:0] next_addr;
  logic [31:0] pc, pc_plus4, if_id_ins, if_id_pc_plus4;
  logic        if_id_valid, align_err;
  int          checks = 0;
  int          errors = 0;

  pc_fetch_stage_if bus ();

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.imem_rdata = rd(bus.imem_addr);
  assign next_addr = seq_mode ? pc_plus4 : next_addr_drv;

  pc_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .next_addr(next_addr), .stall_if(stall_if), .flush_if(flush_if),
    .imem(bus.master), .pc(pc), .pc_plus4(pc_plus4), .if_id_ins(if_id_ins),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .align_err(align_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_if = 1'b0; flush_if = 1'b0; seq_mode = 1'b1;
    next_addr_drv = 32'd0; bus.imem_ready = 1'b1;
    tick();
    tick();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
    checks++; if (if_id_ins !== 32'd0) begin errors++; $display("FAIL reset_ins: got %h expected 0", if_id_ins); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align: got %b expected 0", align_err); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.imem_addr !== 32'h3000 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq_c1: got addr %h req %b expected 3000 1", bus.imem_addr, bus.imem_req); end
    tick();
    checks++; if (bus.imem_addr !== 32'h3004) begin errors++; $display("FAIL seq_c2_addr: got %h expected 3004", bus.imem_addr); end
    checks++; if (if_id_valid !== 1'b1 || if_id_ins !== rd(32'h3000) || if_id_pc_plus4 !== 32'h3004) begin errors++; $display("FAIL seq_c2_ifid: got v%b %h %h expected v1 %h 3004", if_id_valid, if_id_ins, if_id_pc_plus4, rd(32'h3000)); end
    tick();
    checks++; if (bus.imem_addr !== 32'h3008 || if_id_ins !== rd(32'h3004)) begin errors++; $display("FAIL seq_c3: got addr %h ins %h expected 3008 %h", bus.imem_addr, if_id_ins, rd(32'h3004)); end
    $display("test_sequential done");
  endtask

  task automatic test_stall();
    tick();
    stall_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h300C || bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got pc %h req %b expected 300c 0", i, pc, bus.imem_req); end
      checks++; if (if_id_ins !== rd(32'h3008) || if_id_pc_plus4 !== 32'h300C || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid%0d: got %h %h v%b expected %h 300c v1", i, if_id_ins, if_id_pc_plus4, if_id_valid, rd(32'h3008)); end
    end
    stall_if = 1'b0;
    tick();
    checks++; if (if_id_ins !== rd(32'h300C) || if_id_pc_plus4 !== 32'h3010 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_release: got %h %h v%b expected %h 3010 v1", if_id_ins, if_id_pc_plus4, if_id_valid, rd(32'h300C)); end
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_release_pc: got %h expected 3010", pc); end
    tick();
    checks++; if (if_id_ins !== rd(32'h3010) || if_id_pc_plus4 !== 32'h3014) begin errors++; $display("FAIL stall_next: got %h %h expected %h 3014", if_id_ins, if_id_pc_plus4, rd(32'h3010)); end
    $display("test_stall done");
  endtask

  task automatic test_flush();
    seq_mode = 1'b0; next_addr_drv = 32'h3100; flush_if = 1'b1;
    tick();
    checks++; if (pc !== 32'h3100 || if_id_valid !== 1'b0) begin errors++; $display("FAIL flush: got pc %h v%b expected 3100 v0", pc, if_id_valid); end
    flush_if = 1'b0; seq_mode = 1'b1;
    tick();
    checks++; if (if_id_ins !== rd(32'h3100) || if_id_pc_plus4 !== 32'h3104 || if_id_valid !== 1'b1) begin errors++; $display("FAIL flush_next: got %h %h v%b expected %h 3104 v1", if_id_ins, if_id_pc_plus4, if_id_valid, rd(32'h3100)); end
    $display("test_flush done");
  endtask

  task automatic test_drain();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    bus.imem_ready = 1'b0; flush_if = 1'b1; seq_mode = 1'b0; next_addr_drv = 32'h3200;
    tick();
    flush_if = 1'b0; seq_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.imem_addr !== 32'h3008 || bus.imem_req !== 1'b1 || if_id_valid !== 1'b0) begin errors++; $display("FAIL drain_wait%0d: got addr %h req %b v%b expected 3008 1 v0", i, bus.imem_addr, bus.imem_req, if_id_valid); end
      if (i < 2) tick();
    end
    bus.imem_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h3200 || if_id_valid !== 1'b0) begin errors++; $display("FAIL drain_done: got pc %h v%b expected 3200 v0", pc, if_id_valid); end
    tick();
    checks++; if (if_id_ins !== rd(32'h3200) || if_id_valid !== 1'b1) begin errors++; $display("FAIL drain_next: got %h v%b expected %h v1", if_id_ins, if_id_valid, rd(32'h3200)); end
    $display("test_drain done");
  endtask

  task automatic test_wrap();
    seq_mode = 1'b0; next_addr_drv = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got pc %h pc4 %h expected fffffffc 0", pc, pc_plus4); end
    seq_mode = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_ins !== rd(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_next: got addr %h pc4 %h ins %h expected 0 0 %h", bus.imem_addr, if_id_pc_plus4, if_id_ins, rd(32'hFFFF_FFFC)); end
    $display("test_wrap done");
  endtask

  task automatic test_align();
    logic [31:0] exp_pc;
    logic        exp_err;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_pc = 32'h3004; exp_err = 1'b1;
`else
    exp_pc = 32'h3006; exp_err = 1'b0;
`endif
    seq_mode = 1'b0; next_addr_drv = 32'h3006;
    tick();
    checks++; if (pc !== exp_pc || align_err !== exp_err) begin errors++; $display("FAIL align_load: got pc %h err %b expected %h %b", pc, align_err, exp_pc, exp_err); end
    next_addr_drv = 32'h3100;
    tick();
    tick();
    checks++; if (pc !== 32'h3100 || align_err !== exp_err) begin errors++; $display("FAIL align_sticky: got pc %h err %b expected 3100 %b", pc, align_err, exp_err); end
    rst_n = 1'b0; seq_mode = 1'b1;
    tick();
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_clear: got %b expected 0", align_err); end
    rst_n = 1'b1;
    $display("test_align done");
  endtask

  task automatic test_reset_mid();
    bus.imem_ready = 1'b1;
    tick();
    stall_if = 1'b1;
    tick();
    checks++; if (bus.imem_req !== 1'b0 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rmid_hold: got req %b v%b expected 0 v1", bus.imem_req, if_id_valid); end
    rst_n = 1'b0; stall_if = 1'b0;
    tick();
    checks++; if (pc !== 32'h3000 || if_id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_hold_rst: got pc %h v%b req %b expected 3000 v0 0", pc, if_id_valid, bus.imem_req); end
    rst_n = 1'b1; bus.imem_ready = 1'b0; flush_if = 1'b1; seq_mode = 1'b0; next_addr_drv = 32'h3300;
    tick();
    rst_n = 1'b0; bus.imem_ready = 1'b1; flush_if = 1'b0; seq_mode = 1'b1;
    tick();
    checks++; if (pc !== 32'h3000 || if_id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rmid_drain_rst: got pc %h v%b req %b expected 3000 v0 0", pc, if_id_valid, bus.imem_req); end
    rst_n = 1'b1; bus.imem_ready = 1'b0;
    tick();
    checks++; if (pc !== 32'h3000 || if_id_valid !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL rmid_release: got pc %h v%b req %b expected 3000 v0 1", pc, if_id_valid, bus.imem_req); end
    bus.imem_ready = 1'b1;
    tick();
    checks++; if (if_id_ins !== rd(32'h3000) || if_id_valid !== 1'b1 || pc !== 32'h3004) begin errors++; $display("FAIL rmid_fetch: got %h v%b pc %h expected %h v1 3004", if_id_ins, if_id_valid, pc, rd(32'h3000)); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_drain();
    test_wrap();
    test_align();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
